// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin arbiter sharing the top_fifo write port among N_REQ producers.
// Optional build macro FIFO_ARB_STATS_EN adds per-requester word_cnt and a stats_clr input.
module fifo_rr_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 4,
  localparam int GID_W    = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data_in,
  output logic [N_REQ-1:0]        ack,
  input  logic                    fifo_full,
  input  logic                    fifo_err_write,
  output logic                    fifo_write,
  output logic [DATA_W-1:0]       fifo_data_write,
  output logic [GID_W-1:0]        grant_id,
  output logic                    busy,
  output logic [15:0]             stall_cnt,
  output logic [7:0]              err_cnt
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic                    stats_clr,
  output logic [N_REQ*16-1:0]     word_cnt
`endif
);

  localparam int BCW = $clog2(BURST_MAX + 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t           r_state;
  logic [GID_W-1:0] r_grant_id;
  logic [GID_W-1:0] r_last_grant;
  logic [BCW-1:0]   r_burst_cnt;
  logic [15:0]      r_stall_cnt;
  logic [7:0]       r_err_cnt;

  logic             w_req_g;
  logic             w_xfer;
  logic             w_last_word;
  logic [GID_W-1:0] w_pick;
  logic [GID_W:0]   w_idx;
  logic [N_REQ-1:0] w_ack;
  logic             w_clr;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

`ifdef FIFO_ARB_STATS_EN
  assign w_clr = stats_clr;
`else
  assign w_clr = 1'b0;
`endif

  assign w_req_g     = req[r_grant_id];
  assign w_xfer      = (r_state == S_GRANT) && w_req_g && !fifo_full;
  assign w_last_word = (r_burst_cnt == BCW'(BURST_MAX - 1));

  // Scan downward so the requester closest after last_grant wins.
  always_comb begin
    w_pick = '0;
    w_idx  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_idx = {1'b0, r_last_grant} + (GID_W+1)'(k);
      if (w_idx >= (GID_W+1)'(N_REQ)) w_idx = w_idx - (GID_W+1)'(N_REQ);
      if (req[w_idx[GID_W-1:0]]) w_pick = w_idx[GID_W-1:0];
    end
  end

  always_comb begin
    w_ack = '0;
    if (w_xfer) w_ack[r_grant_id] = 1'b1;
  end

  assign ack             = w_ack;
  assign fifo_write      = w_xfer;
  assign fifo_data_write = w_xfer ? data_in[r_grant_id*DATA_W +: DATA_W] : '0;
  assign grant_id        = r_grant_id;
  assign busy            = (r_state == S_GRANT);
  assign stall_cnt       = r_stall_cnt;
  assign err_cnt         = r_err_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_grant_id   <= '0;
      r_last_grant <= GID_W'(N_REQ - 1);
      r_burst_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_grant_id  <= w_pick;
            r_burst_cnt <= '0;
            r_state     <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (!w_req_g) begin
            r_last_grant <= r_grant_id;
            r_state      <= S_IDLE;
          end else if (w_xfer) begin
            if (w_last_word) begin
              r_last_grant <= r_grant_id;
              r_state      <= S_IDLE;
            end else begin
              r_burst_cnt <= r_burst_cnt + BCW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A clear wins over any increment landing in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_err_cnt   <= '0;
    end else if (w_clr) begin
      r_stall_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      if ((r_state == S_GRANT) && w_req_g && fifo_full) r_stall_cnt <= sat_inc16(r_stall_cnt);
      if (fifo_err_write) r_err_cnt <= sat_inc8(r_err_cnt);
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] r_word_cnt [N_REQ];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_REQ; i++) r_word_cnt[i] <= '0;
    end else if (stats_clr) begin
      for (int i = 0; i < N_REQ; i++) r_word_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (w_ack[i]) r_word_cnt[i] <= sat_inc16(r_word_cnt[i]);
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_wc
    assign word_cnt[g*16 +: 16] = r_word_cnt[g];
  end
`endif

endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// Self-checking bench for fifo_rr_write_arbiter: directed scenarios plus randomized traffic
// compared each cycle against a transaction-level round-robin model.
module tb_fifo_rr_write_arbiter;
  localparam int N_REQ     = 4;
  localparam int DATA_W    = 32;
  localparam int BURST_MAX = 4;
  localparam int GID_W     = 2;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic [N_REQ-1:0]        req = '0;
  logic [N_REQ*DATA_W-1:0] data_in = '0;
  logic [N_REQ-1:0]        ack;
  logic                    fifo_full = 1'b0;
  logic                    fifo_err_write = 1'b0;
  logic                    fifo_write;
  logic [DATA_W-1:0]       fifo_data_write;
  logic [GID_W-1:0]        grant_id;
  logic                    busy;
  logic [15:0]             stall_cnt;
  logic [7:0]              err_cnt;
`ifdef FIFO_ARB_STATS_EN
  logic                    stats_clr = 1'b0;
  logic [N_REQ*16-1:0]     word_cnt;
`endif

  fifo_rr_write_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in), .ack(ack),
    .fifo_full(fifo_full), .fifo_err_write(fifo_err_write), .fifo_write(fifo_write),
    .fifo_data_write(fifo_data_write), .grant_id(grant_id), .busy(busy),
    .stall_cnt(stall_cnt), .err_cnt(err_cnt)
`ifdef FIFO_ARB_STATS_EN
    , .stats_clr(stats_clr), .word_cnt(word_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level model state
  bit m_busy;
  int m_gid, m_last, m_words, m_stall, m_err;
  int m_wc[N_REQ];

  // Producer bookkeeping and observed write log
  int sent[N_REQ];
  int want[N_REQ];
  logic [DATA_W-1:0] wq[$];
  int gq[$];
  logic [63:0] wtrace;
  int full_after = -1;
  int full_len = 0;
  int full_done = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_gid = 0; m_last = N_REQ - 1; m_words = 0; m_stall = 0; m_err = 0;
    for (int i = 0; i < N_REQ; i++) m_wc[i] = 0;
  endtask

  task automatic m_step();
    bit found;
    if (fifo_err_write) m_err = (m_err < 255) ? m_err + 1 : 255;
    if (m_busy) begin
      if (!req[m_gid]) begin
        m_busy = 0; m_last = m_gid;
      end else if (fifo_full) begin
        m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
      end else begin
        m_words++;
        m_wc[m_gid] = (m_wc[m_gid] < 65535) ? m_wc[m_gid] + 1 : 65535;
        if (m_words == BURST_MAX) begin m_busy = 0; m_last = m_gid; end
      end
    end else if (req != '0) begin
      found = 0;
      for (int k = 1; k <= N_REQ; k++)
        if (!found && req[(m_last + k) % N_REQ]) begin
          found = 1; m_gid = (m_last + k) % N_REQ;
        end
      m_busy = 1; m_words = 0;
    end
`ifdef FIFO_ARB_STATS_EN
    if (stats_clr) begin
      m_stall = 0; m_err = 0;
      for (int i = 0; i < N_REQ; i++) m_wc[i] = 0;
    end
`endif
  endtask

  // Called with inputs already driven for this cycle; returns at the next falling edge.
  task automatic cycle();
    logic xf;
    logic [N_REQ-1:0] eack;
    logic [DATA_W-1:0] ed;
    #1;
    xf = m_busy && req[m_gid] && !fifo_full;
    eack = '0;
    if (xf) eack[m_gid] = 1'b1;
    ed = xf ? data_in[m_gid*DATA_W +: DATA_W] : '0;
    chk("ack", ack, eack);
    chk("fifo_write", fifo_write, xf);
    chk("fifo_data_write", fifo_data_write, ed);
    chk("grant_id", grant_id, m_gid);
    chk("busy", busy, m_busy);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("err_cnt", err_cnt, m_err);
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < N_REQ; i++) chk("word_cnt", word_cnt[i*16 +: 16], m_wc[i]);
`endif
    for (int i = 0; i < N_REQ; i++) if (ack[i]) sent[i]++;
    if (fifo_write) begin wq.push_back(fifo_data_write); gq.push_back(m_gid); end
    wtrace = {wtrace[62:0], fifo_write};
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic clear_log();
    wq.delete(); gq.delete(); wtrace = '0;
    for (int i = 0; i < N_REQ; i++) begin sent[i] = 0; want[i] = 0; end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req = '0; fifo_full = 0; fifo_err_write = 0;
`ifdef FIFO_ARB_STATS_EN
    stats_clr = 0;
`endif
    model_reset();
    clear_log();
    full_after = -1; full_len = 0; full_done = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Producers hold req until their quota of words has been acked; data is 0xA0+i.
  task automatic prod(input int n);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        req[i] = (sent[i] < want[i]);
        data_in[i*DATA_W +: DATA_W] = 32'hA0 + i;
      end
      fifo_full = 1'b0;
      if (full_after >= 0 && sent[1] >= full_after && full_done < full_len) begin
        fifo_full = 1'b1; full_done++;
      end
      cycle();
    end
  endtask

  initial begin
    model_reset();
    clear_log();

    // Reset held with all requests active
    req = 4'hF;
    for (int i = 0; i < N_REQ; i++) data_in[i*DATA_W +: DATA_W] = 32'hA0 + i;
    @(negedge clk); #1;
    chk("rst_ack", ack, 4'h0);
    chk("rst_fifo_write", fifo_write, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant_id", grant_id, 2'd0);
    chk("rst_stall_cnt", stall_cnt, 16'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("t1_idle_write", fifo_write, 1'b0);
    cycle();
    #1;
    chk("t1_busy", busy, 1'b1);
    chk("t1_grant", grant_id, 2'd0);
    chk("t1_data", fifo_data_write, 32'hA0);
    cycle();

    // Single requester, 10 words: bursts 4,4,2 with idle arbitration cycles
    do_reset();
    want[2] = 10;
    prod(16);
    chk("t2_trace", wtrace[15:0], 16'h7BD8);
    chk("t2_writes", wq.size(), 10);
    chk("t2_acks", sent[2], 10);

    // All requesting: round robin 0,1,2,3,0 with 4 words each
    do_reset();
    for (int i = 0; i < N_REQ; i++) want[i] = 8;
    prod(26);
    chk("t3_nwrites", wq.size(), 20);
    for (int k = 0; k < 16; k++) chk("t3_word", wq[k], 32'hA0 + k / 4);
    chk("t3_grant4", gq[4], 1);
    chk("t3_grant12", gq[12], 3);
    chk("t3_grant16", gq[16], 0);

    // Full stalls requester 1 for 5 cycles mid-burst
    do_reset();
    want[1] = 4; full_after = 2; full_len = 5;
    prod(14);
    chk("t4_stall_cnt", stall_cnt, 16'd5);
    chk("t4_words", sent[1], 4);
    chk("t4_writes", wq.size(), 4);

    // Requester 3 drops after 2 words; next pick starts at 0
    clear_log();
    want[3] = 2;
    prod(6);
    chk("t5_words", wq.size(), 2);
    chk("t5_gid", gq[0], 3);
    clear_log();
    want[0] = 1; want[2] = 1;
    prod(8);
    chk("t5_first_after", gq[0], 0);
    chk("t5_second_after", gq[1], 2);

    // Error pulse counting and saturation
    do_reset();
    fifo_err_write = 1'b1;
    repeat (3) cycle();
    fifo_err_write = 1'b0;
    #1 chk("t6_err3", err_cnt, 8'd3);
    fifo_err_write = 1'b1;
    repeat (300) cycle();
    fifo_err_write = 1'b0;
    #1 chk("t6_err_sat", err_cnt, 8'hFF);
`ifdef FIFO_ARB_STATS_EN
    stats_clr = 1'b1;
    cycle();
    stats_clr = 1'b0;
    #1 chk("t6_clr", err_cnt, 8'd0);
`endif

    // Asynchronous reset in the middle of a burst
    do_reset();
    want[1] = 100;
    prod(3);
    req[1] = 1'b1;
    #1 chk("t7_pre_write", fifo_write, 1'b1);
    reset = 1'b0;
    #1;
    chk("t7_write_drop", fifo_write, 1'b0);
    chk("t7_ack_drop", ack, 4'h0);
    chk("t7_busy_drop", busy, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // Randomized traffic
    req = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if ($urandom_range(7) == 0) req[i] = ~req[i];
        data_in[i*DATA_W +: DATA_W] = $urandom;
      end
      fifo_full      = ($urandom_range(3) == 0);
      fifo_err_write = ($urandom_range(15) == 0);
`ifdef FIFO_ARB_STATS_EN
      stats_clr      = ($urandom_range(63) == 0);
`endif
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
